// File: rtl/hazard_pkg.sv
// Shared types and helpers for the decode-side hazard unit.
package hazard_pkg;

  // Storage widths for the scoreboard entry fields. The entry struct is
  // shared by every instance, so it is sized for the widest supported
  // register number and stage index; modules zero-extend into it.
  localparam int REG_BITS_MAX   = 8;
  localparam int STAGE_BITS_MAX = 8;

  // Forward select meaning "read the register file".
  localparam int FWD_REGFILE = 0;

  // One in-flight register write: which register it targets and the first
  // back-end stage at which its result can be forwarded.
  typedef struct packed {
    logic                      valid;
    logic [REG_BITS_MAX-1:0]   regnum;
    logic [STAGE_BITS_MAX-1:0] ready;
  } sb_entry_t;

  // Width of a forward select able to name regfile (0) or stage 1..depth.
  function automatic int fwd_sel_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_src_check.sv
// Per-operand dependency check: finds the youngest in-flight producer of a
// source register and decides between forwarding from its stage or
// declaring a hazard that must stall decode.
module hazard_src_check
  import hazard_pkg::*;
#(
  parameter int REG_BITS   = 5,
  parameter int DEPTH      = 3,
  parameter bit FORWARD_EN = 1'b1,
  parameter int FS         = fwd_sel_bits(DEPTH)
) (
  input  logic [REG_BITS-1:0] src_i,
  input  logic                used_i,
  input  sb_entry_t [DEPTH:1] sb_i,
  output logic                hazard_o,
  output logic [FS-1:0]       fwd_o
);

  logic [REG_BITS_MAX-1:0] src_ext;

  // Widen the source register to the stored entry field width.
  always_comb begin
    src_ext = REG_BITS_MAX'(src_i);
  end

  // Priority search from stage 1 upward: the first match is the youngest
  // producer, so older writers of the same register are ignored.
  always_comb begin
    logic found;
    found    = 1'b0;
    hazard_o = 1'b0;
    fwd_o    = FS'(FWD_REGFILE);
    if (used_i && (src_i != '0)) begin
      for (int k = 1; k <= DEPTH; k++) begin
        if (!found && sb_i[k].valid && (sb_i[k].regnum == src_ext)) begin
          found = 1'b1;
          if (FORWARD_EN && (k >= int'(sb_i[k].ready))) begin
            fwd_o = FS'(k);
          end else begin
            hazard_o = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit for a DEPTH-stage back end. A shift register
// follows every in-flight register write; each source operand gets a
// forward select, or decode stalls and a bubble enters the pipe.
//
// stall is a plain hold request to PC and IF/DE, not a valid/ready
// handshake: the scoreboard itself always advances one stage per clock,
// and nothing here depends on another unit's stall.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_BITS   = 5,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter bit FORWARD_EN = 1'b1,
  parameter int FS         = fwd_sel_bits(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_valid,
  input  logic [REG_BITS-1:0] rs,
  input  logic [REG_BITS-1:0] rt,
  input  logic                rs_used,
  input  logic                rt_used,
  input  logic                dec_regwrite,
  input  logic [REG_BITS-1:0] dec_wr_regnum,
  input  logic                dec_is_load,
  input  logic                flush,
  output logic                stall,
  output logic [FS-1:0]       fwd_a,
  output logic [FS-1:0]       fwd_b,
  output logic [31:0]         stall_count,
  output logic [FS-1:0]       occupancy
);

  sb_entry_t [DEPTH:1] sb_q, sb_d;
  sb_entry_t           new_entry;
  logic [31:0]         stall_count_q, stall_count_d;
  logic                haz_a, haz_b;
  logic [FS-1:0]       fwd_a_raw, fwd_b_raw;
  logic                issue;

  hazard_src_check #(
    .REG_BITS  (REG_BITS),
    .DEPTH     (DEPTH),
    .FORWARD_EN(FORWARD_EN),
    .FS        (FS)
  ) u_chk_rs (
    .src_i   (rs),
    .used_i  (rs_used),
    .sb_i    (sb_q),
    .hazard_o(haz_a),
    .fwd_o   (fwd_a_raw)
  );

  hazard_src_check #(
    .REG_BITS  (REG_BITS),
    .DEPTH     (DEPTH),
    .FORWARD_EN(FORWARD_EN),
    .FS        (FS)
  ) u_chk_rt (
    .src_i   (rt),
    .used_i  (rt_used),
    .sb_i    (sb_q),
    .hazard_o(haz_b),
    .fwd_o   (fwd_b_raw)
  );

  // Stall combine: a flush squashes decode, so it overrides any hazard.
  always_comb begin
    stall = dec_valid && !flush && (haz_a || haz_b);
    issue = dec_valid && !flush && !(haz_a || haz_b);
  end

  // Forward selects are only meaningful for an instruction that is moving.
  always_comb begin
    fwd_a = FS'(FWD_REGFILE);
    fwd_b = FS'(FWD_REGFILE);
    if (dec_valid && !stall) begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
    end
  end

  // Build the entry for the decode instruction; r0 writes are not tracked.
  always_comb begin
    new_entry = '0;
    if (dec_regwrite && (dec_wr_regnum != '0)) begin
      new_entry.valid  = 1'b1;
      new_entry.regnum = REG_BITS_MAX'(dec_wr_regnum);
      new_entry.ready  = dec_is_load ? STAGE_BITS_MAX'(LOAD_READY)
                                     : STAGE_BITS_MAX'(ALU_READY);
    end
  end

  // Next scoreboard: everything advances; stage 1 takes the issued
  // instruction or a bubble, the last stage retires.
  always_comb begin
    sb_d    = '0;
    sb_d[1] = issue ? new_entry : '0;
    for (int k = 2; k <= DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
  end

  // Saturating count of stall cycles.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // Number of valid writing entries currently in flight.
  always_comb begin
    occupancy = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      occupancy = occupancy + FS'(sb_q[k].valid);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_q          <= '0;
      stall_count_q <= '0;
    end else begin
      sb_q          <= sb_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
